// File: rtl/m_alarm_watch_pkg.sv
// Shared definitions for the alarm watch: FSM states, BCD limits and
// BCD helpers for increment and 24h-to-12h display conversion.
package m_alarm_watch_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_AH = 3'd3,
        ST_SET_AM = 3'd4
    } state_t;

    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_H  = 8'h23;
    localparam logic [7:0] BCD_NOON   = 8'h12;

    typedef struct packed {
        logic       pm;
        logic [7:0] hour;
    } disp12_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Internal 00-23 BCD hour -> 01-12 BCD hour plus pm flag.
    function automatic disp12_t to_12h(input logic [7:0] h);
        logic [4:0] b;
        logic [4:0] d;
        disp12_t    r;
        b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
        if (b == 5'd0)
            d = 5'd12;
        else if (b > 5'd12)
            d = b - 5'd12;
        else
            d = b;
        r.pm   = (b >= 5'd12);
        r.hour = (d >= 5'd10) ? {4'd1, 4'(d - 5'd10)} : {4'd0, 4'(d)};
        return r;
    endfunction

endpackage

// File: rtl/m_alarm_watch_bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with synchronous clear and wrap carry.
module m_bcd_mod_counter
    import m_alarm_watch_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_MAX_MS
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_reg;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            value_reg <= 8'h00;
        else if (clr)
            value_reg <= 8'h00;
        else if (en)
            value_reg <= bcd_inc(value_reg, MAX);
    end

    // A clear wins over the increment, so it must not leak a carry either.
    assign carry = en && !clr && (value_reg == MAX);
    assign value = value_reg;

endmodule

// File: rtl/m_alarm_watch.sv
// Digital watch with internal 1 s prescaler, button-driven set FSM and
// a timed alarm; time is held as 24-hour BCD and converted for display.
module m_alarm_watch
    import m_alarm_watch_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int H24       = 1,
    parameter int ALARM_LEN = 60
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       mode_sw,
    input  logic       inc_sw,
    input  logic       alarm_en,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       pm,
    output logic       alarm,
    output logic [2:0] state,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg;
    logic          mode_d_reg, inc_d_reg, mode_press_reg, inc_press_reg;
    logic          alarm_reg;
    logic [7:0]    alarm_cnt_reg;

    logic [7:0] sec_val, min_val, hour_val, ah_val, am_val;
    logic       sec_carry, min_carry, ah_carry_unused, am_carry_unused;
    logic       running, tick_w, trigger, any_press, mode_eff, inc_eff;
    logic       sec_clr, hour_inc, min_inc, ah_inc, am_inc;
    logic [7:0] min_after, hour_after;

    assign running = (state_reg != ST_SET_H) && (state_reg != ST_SET_M);
    assign tick_w  = running && (presc_reg == PW'(TICK_DIV - 1));

    // Alarm fires on the tick whose result equals alarm_h:alarm_m:00.
    assign min_after  = bcd_inc(min_val, BCD_MAX_MS);
    assign hour_after = (min_val == BCD_MAX_MS) ? bcd_inc(hour_val, BCD_MAX_H) : hour_val;
    assign trigger    = tick_w && alarm_en && (sec_val == BCD_MAX_MS)
                        && (min_after == am_val) && (hour_after == ah_val);

    // A press during (or coinciding with) an alarm only dismisses it.
    assign any_press = mode_press_reg || inc_press_reg;
    assign mode_eff  = mode_press_reg && !alarm_reg && !trigger;
    assign inc_eff   = inc_press_reg && !alarm_reg && !trigger;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg      <= ST_RUN;
            presc_reg      <= '0;
            mode_d_reg     <= 1'b0;
            inc_d_reg      <= 1'b0;
            mode_press_reg <= 1'b0;
            inc_press_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mode_d_reg     <= mode_sw;
            inc_d_reg      <= inc_sw;
            mode_press_reg <= mode_sw && !mode_d_reg;
            inc_press_reg  <= inc_sw && !inc_d_reg;
            if (!running || sec_clr || tick_w)
                presc_reg <= '0;
            else
                presc_reg <= presc_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        sec_clr    = 1'b0;
        hour_inc   = 1'b0;
        min_inc    = 1'b0;
        ah_inc     = 1'b0;
        am_inc     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (mode_eff) begin
                    state_next = ST_SET_H;
                    sec_clr    = 1'b1;
                end
            end
            ST_SET_H: begin
                hour_inc = inc_eff;
                if (mode_eff) state_next = ST_SET_M;
            end
            ST_SET_M: begin
                min_inc = inc_eff;
                if (mode_eff) state_next = ST_SET_AH;
            end
            ST_SET_AH: begin
                ah_inc = inc_eff;
                if (mode_eff) state_next = ST_SET_AM;
            end
            ST_SET_AM: begin
                am_inc = inc_eff;
                if (mode_eff) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            alarm_reg     <= 1'b0;
            alarm_cnt_reg <= 8'd0;
        end else if (alarm_reg && (any_press || !alarm_en
                                   || (tick_w && alarm_cnt_reg == 8'd1))) begin
            alarm_reg <= 1'b0;
        end else if (trigger && !any_press) begin
            alarm_reg     <= 1'b1;
            alarm_cnt_reg <= 8'(ALARM_LEN);
        end else if (alarm_reg && tick_w) begin
            alarm_cnt_reg <= alarm_cnt_reg - 8'd1;
        end
    end

    m_bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_sec (
        .clk(clk), .n_reset(n_reset), .en(tick_w), .clr(sec_clr),
        .value(sec_val), .carry(sec_carry));

    m_bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_min (
        .clk(clk), .n_reset(n_reset), .en(sec_carry || min_inc), .clr(1'b0),
        .value(min_val), .carry(min_carry));

    // Minute wraps from the set button must not reach the hours.
    m_bcd_mod_counter #(.MAX(BCD_MAX_H)) u_hour (
        .clk(clk), .n_reset(n_reset), .en((min_carry && tick_w) || hour_inc), .clr(1'b0),
        .value(hour_val), .carry());

    m_bcd_mod_counter #(.MAX(BCD_MAX_H)) u_alarm_h (
        .clk(clk), .n_reset(n_reset), .en(ah_inc), .clr(1'b0),
        .value(ah_val), .carry(ah_carry_unused));

    m_bcd_mod_counter #(.MAX(BCD_MAX_MS)) u_alarm_m (
        .clk(clk), .n_reset(n_reset), .en(am_inc), .clr(1'b0),
        .value(am_val), .carry(am_carry_unused));

    logic       show_alarm;
    logic [7:0] disp_h24;
    disp12_t    disp12;

    assign show_alarm = (state_reg == ST_SET_AH) || (state_reg == ST_SET_AM);
    assign disp_h24   = show_alarm ? ah_val : hour_val;
    assign disp12     = to_12h(disp_h24);

    assign hour  = (H24 != 0) ? disp_h24 : disp12.hour;
    assign pm    = (H24 != 0) ? 1'b0 : disp12.pm;
    assign min   = show_alarm ? am_val : min_val;
    assign sec   = sec_val;
    assign alarm = alarm_reg;
    assign state = state_reg;
    assign tick  = tick_w;

endmodule

// File: tb/tb_m_alarm_watch.sv
// Directed bench for m_alarm_watch: 24-hour and 12-hour instances share stimulus.
module tb_m_alarm_watch;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       mode_sw = 1'b0;
    logic       inc_sw = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] hour, min, sec, hour12, min12, sec12;
    logic       pm, pm12, alarm, alarm12, tick, tick12;
    logic [2:0] state, state12;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    m_alarm_watch #(.TICK_DIV(4), .H24(1), .ALARM_LEN(3)) dut (
        .clk(clk), .n_reset(n_reset), .mode_sw(mode_sw), .inc_sw(inc_sw),
        .alarm_en(alarm_en), .hour(hour), .min(min), .sec(sec), .pm(pm),
        .alarm(alarm), .state(state), .tick(tick));

    m_alarm_watch #(.TICK_DIV(4), .H24(0), .ALARM_LEN(3)) dut12 (
        .clk(clk), .n_reset(n_reset), .mode_sw(mode_sw), .inc_sw(inc_sw),
        .alarm_en(alarm_en), .hour(hour12), .min(min12), .sec(sec12), .pm(pm12),
        .alarm(alarm12), .state(state12), .tick(tick12));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_sw = 1'b1; step(1);
        mode_sw = 1'b0; step(1);
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            inc_sw = 1'b1; step(1);
            inc_sw = 1'b0; step(1);
        end
    endtask

    // From RUN at hh:mm:xx: freeze at hh:mm:00, bump alarm minute, return to RUN.
    // Ends two edges before the tick that reaches the next minute.
    task automatic rearm();
        repeat (3) press_mode();
        press_mode();
        press_inc(1);
        press_mode();
        step(232);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run exceeded time limit (observed 200000 ns, required less)");
        $fatal(1);
    end

    initial begin
        #1 n_reset = 1'b0;
        #1;
        chk("rst_time", {hour, min, sec}, 24'h000000);
        chk("rst_ctrl", {state, alarm, tick, pm}, 6'd0);
        chk("rst_h12", {pm12, hour12}, 9'h012);
        step(1);
        n_reset = 1'b1;

        step(3);
        chk("first_tick", {tick, sec}, {1'b1, 8'h00});
        step(1);
        chk("first_sec", {tick, sec}, {1'b0, 8'h01});
        step(236);
        chk("run_1min", {hour, min, sec}, 24'h000100);

        press_mode();
        chk("enter_set_h", {state, sec}, {3'd1, 8'h00});
        press_inc(12);
        chk("h24_noon", hour, 8'h12);
        chk("h12_noon", {pm12, hour12}, 9'h112);
        press_inc(1);
        chk("h12_13", {pm12, hour12}, 9'h101);
        press_inc(10);
        chk("hour_23", hour, 8'h23);
        chk("h12_23", {pm12, hour12}, 9'h111);
        chk("set_frozen", {sec, tick}, 9'd0);

        press_mode();
        chk("enter_set_m", state, 3'd2);
        press_inc(58);
        chk("min_59", min, 8'h59);
        press_inc(1);
        chk("min_wrap_nocarry", {hour, min}, 16'h2300);
        press_inc(59);
        chk("time_2359", {hour, min, sec}, 24'h235900);

        press_mode();
        chk("set_ah_shows_alarm", {state, hour, min}, {3'd3, 16'h0000});
        step(3);
        chk("resume_tick", {tick, sec}, {1'b1, 8'h00});
        step(1);
        chk("resume_sec", sec, 8'h01);
        press_mode();
        press_inc(2);
        chk("alarm_min_set", {state, hour, min}, {3'd4, 16'h0002});
        press_mode();
        chk("back_run", {state, hour, min, sec}, {3'd0, 24'h235903});
        step(224);
        chk("t235959", {hour, min, sec}, 24'h235959);
        step(4);
        chk("rollover", {hour, min, sec}, 24'h000000);
        chk("h12_midnight", {pm12, hour12}, 9'h012);

        alarm_en = 1'b1;
        step(472);
        chk("t000158", {hour, min, sec}, 24'h000158);
        step(7);
        chk("pre_trigger", {tick, alarm}, 2'b10);
        step(1);
        chk("alarm_on", {alarm, hour, min, sec}, {1'b1, 24'h000200});
        step(11);
        chk("alarm_held", alarm, 1'b1);
        step(1);
        chk("alarm_expire", {alarm, sec}, {1'b0, 8'h03});

        rearm();
        step(1);
        chk("tick_0259", {tick, alarm, min, sec}, {2'b10, 16'h0259});
        step(1);
        chk("alarm2_on", {alarm, min, sec}, {1'b1, 16'h0300});
        mode_sw = 1'b1; step(1);
        chk("press_pending", alarm, 1'b1);
        mode_sw = 1'b0; step(1);
        chk("dismiss", {alarm, state, hour, min}, {1'b0, 3'd0, 16'h0003});

        rearm();
        mode_sw = 1'b1; step(1);
        chk("trig_press_tick", {tick, alarm}, 2'b10);
        mode_sw = 1'b0; step(1);
        chk("trig_press", {alarm, state, min, sec}, {1'b0, 3'd0, 16'h0400});

        rearm();
        step(2);
        chk("alarm3_on", {alarm, min}, {1'b1, 8'h05});
        alarm_en = 1'b0; step(1);
        chk("en_drop", alarm, 1'b0);
        alarm_en = 1'b1;

        rearm();
        step(2);
        chk("alarm4_on", {alarm, min}, {1'b1, 8'h06});
        #3 n_reset = 1'b0;
        #1;
        chk("arst_alarm", {alarm, tick, state}, 5'd0);
        chk("arst_alarm_time", {hour, min, sec}, 24'h000000);
        step(1);
        n_reset = 1'b1;

        step(2);
        mode_sw = 1'b1; step(1);
        chk("tick_with_press", tick, 1'b1);
        mode_sw = 1'b0; step(1);
        chk("press_over_tick", {state, sec}, {3'd1, 8'h00});
        press_mode();
        press_inc(5);
        chk("set_m_min5", {state, min}, {3'd2, 8'h05});
        #3 n_reset = 1'b0;
        #1;
        chk("arst_set_m", {state, hour, min, sec}, {3'd0, 24'h000000});
        chk("arst_h12", {pm12, hour12}, 9'h012);
        step(1);
        n_reset = 1'b1;
        step(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
